os_out_collector: RTL and testbench



---
 rtl/os_out_collector_pkg.sv | 13 +
 rtl/os_col_fifo.sv | 74 +++++++
 rtl/os_out_collector.sv | 98 +++++++++
 tb/tb_os_out_collector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/os_out_collector_pkg.sv
// Shared defaults and types for the OS-mode output collector.
package os_out_collector_pkg;

  localparam int COL       = 8;
  localparam int PSUM_BW   = 16;
  localparam int DEPTH     = 16;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int OVF_CNT_W = 8;

  typedef logic [PSUM_BW-1:0] psum_t;

endpackage

// File: rtl/os_col_fifo.sv
// Single-column psum FIFO: push/pop, occupancy count, full/empty and sticky
// overflow. Storage is intentionally not reset; only pointers and counts are.
module os_col_fifo
  import os_out_collector_pkg::*;
#(
  parameter int depth   = DEPTH,
  parameter int psum_bw = PSUM_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] head,
  output logic               full,
  output logic               empty,
  output logic               ovf
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;

  logic [psum_bw-1:0] mem_r [depth];
  logic [ptr_w-1:0]   wr_ptr_r;
  logic [ptr_w-1:0]   rd_ptr_r;
  logic [cnt_w-1:0]   count_r;
  logic               ovf_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Status and accepted push/pop; a pop in the same cycle frees a full slot.
  always_comb begin
    full      = (count_r == cnt_w'(depth));
    empty     = (count_r == {cnt_w{1'b0}});
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {ptr_w{1'b0}};
      rd_ptr_r <= {ptr_w{1'b0}};
      count_r  <= {cnt_w{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
      if (push & full & ~do_pop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign head = mem_r[rd_ptr_r];
  assign ovf  = ovf_r;

endmodule

// File: rtl/os_out_collector.sv
// Collects per-column OS psums (one entry per valid rising edge) into column
// FIFOs and presents complete rows. Optional macro OS_COLLECT_OVF_CNT_EN adds ovf_cnt.
module os_out_collector
  import os_out_collector_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] os_in,
  input  logic [col-1:0]         os_in_valid,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] o_data,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [col-1:0]         o_ovf
`ifdef OS_COLLECT_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]   ovf_cnt
`endif
);

  logic [col-1:0] vld_r;
  logic [col-1:0] push_s;
  logic [col-1:0] full_s;
  logic [col-1:0] empty_s;
  logic           pop_s;

  // Previous-cycle valid for rising-edge capture; cleared so a valid high
  // straight out of reset is captured once.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r <= {col{1'b0}};
    end else begin
      vld_r <= os_in_valid;
    end
  end

  // Edge pushes and row-level status straight from the column counts.
  always_comb begin
    push_s  = os_in_valid & ~vld_r;
    o_valid = ~|empty_s;
    o_empty = &empty_s;
    o_full  = |full_s;
    pop_s   = rd & o_valid;
  end

  for (genvar c = 0; c < col; c++) begin : g_col
    os_col_fifo #(
      .depth   (depth),
      .psum_bw (psum_bw)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s[c]),
      .pop   (pop_s),
      .din   (os_in[c*psum_bw +: psum_bw]),
      .head  (o_data[c*psum_bw +: psum_bw]),
      .full  (full_s[c]),
      .empty (empty_s[c]),
      .ovf   (o_ovf[c])
    );
  end

`ifdef OS_COLLECT_OVF_CNT_EN
  logic [col-1:0]         drop_s;
  logic [15:0]            drop_sum_s;
  logic [15:0]            ovf_next_s;
  logic [OVF_CNT_W-1:0]   ovf_cnt_r;

  // Dropped pushes this cycle, summed over all columns.
  always_comb begin
    drop_s     = push_s & full_s & ~{col{pop_s}};
    drop_sum_s = 16'd0;
    for (int c = 0; c < col; c++) begin
      drop_sum_s = drop_sum_s + {15'd0, drop_s[c]};
    end
    ovf_next_s = {8'd0, ovf_cnt_r} + drop_sum_s;
  end

  // Saturating dropped-push counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_r <= 8'd0;
    end else if (ovf_next_s > 16'd255) begin
      ovf_cnt_r <= 8'd255;
    end else begin
      ovf_cnt_r <= ovf_next_s[7:0];
    end
  end

  assign ovf_cnt = ovf_cnt_r;
`endif

endmodule

// File: tb/tb_os_out_collector.sv
// Self-checking bench for os_out_collector against a queue-based reference model.
module tb_os_out_collector;

  localparam int NC = 8;
  localparam int BW = 16;
  localparam int DP = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC*BW-1:0] os_in;
  logic [NC-1:0]   os_in_valid;
  logic            rd;
  logic [NC*BW-1:0] o_data;
  logic            o_valid;
  logic            o_full;
  logic            o_empty;
  logic [NC-1:0]   o_ovf;
`ifdef OS_COLLECT_OVF_CNT_EN
  logic [7:0]      ovf_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef logic [BW-1:0] pq_t [$];
  pq_t        mq [NC];
  logic [NC-1:0] m_prev;
  logic [NC-1:0] m_ovf;
  int         m_cnt;

  os_out_collector dut (
    .clk         (clk),
    .reset       (reset),
    .os_in       (os_in),
    .os_in_valid (os_in_valid),
    .rd          (rd),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_ovf       (o_ovf)
`ifdef OS_COLLECT_OVF_CNT_EN
    ,
    .ovf_cnt     (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit m_valid();
    for (int c = 0; c < NC; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_empty();
    for (int c = 0; c < NC; c++) if (mq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int c = 0; c < NC; c++) if (mq[c].size() == DP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NC*BW-1:0] m_data();
    logic [NC*BW-1:0] d;
    d = '0;
    for (int c = 0; c < NC; c++) if (mq[c].size() != 0) d[c*BW +: BW] = mq[c][0];
    return d;
  endfunction

  function automatic logic [NC*BW-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference behaviour for the inputs sampled at this clock edge.
  task automatic model_step();
    bit pop;
    int drops;
    if (reset) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_prev = '0;
      m_ovf  = '0;
      m_cnt  = 0;
    end else begin
      pop   = rd && m_valid();
      drops = 0;
      for (int c = 0; c < NC; c++) begin
        if (pop) void'(mq[c].pop_front());
        if (os_in_valid[c] && !m_prev[c]) begin
          if (mq[c].size() < DP) mq[c].push_back(os_in[c*BW +: BW]);
          else begin
            m_ovf[c] = 1'b1;
            drops++;
          end
        end
      end
      m_prev = os_in_valid;
      m_cnt  = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse(input logic [NC-1:0] mask, input logic [NC*BW-1:0] data);
    os_in       = data;
    os_in_valid = mask;
    tick();
    os_in_valid = '0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    rd = 1'b0; os_in_valid = '0; os_in = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset o_valid: got %b want 0", o_valid); end
    n_vec++; if (o_full !== 1'b0) begin n_err++; $display("FAIL reset o_full: got %b want 0", o_full); end
    n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL reset o_empty: got %b want 1", o_empty); end
    n_vec++; if (o_ovf !== 8'h00) begin n_err++; $display("FAIL reset o_ovf: got %h want 00", o_ovf); end
`ifdef OS_COLLECT_OVF_CNT_EN
    n_vec++; if (ovf_cnt !== 8'd0) begin n_err++; $display("FAIL reset ovf_cnt: got %0d want 0", ovf_cnt); end
`endif
  endtask

  task automatic test_single_row();
    logic [NC*BW-1:0] row;
    for (int c = 0; c < NC; c++) row[c*BW +: BW] = 16'(c + 1);
    os_in = row; os_in_valid = 8'hFF;
    tick();
    os_in_valid = '0;
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL single_row o_valid: got %b want 1", o_valid); end
    n_vec++; if (o_data !== row || row !== m_data()) begin n_err++; $display("FAIL single_row o_data: got %h want %h", o_data, row); end
    rd = 1'b1; tick(); rd = 1'b0;
    n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL single_row o_empty: got %b want 1", o_empty); end
  endtask

  task automatic test_held_level();
    do_reset();
    os_in = '0; os_in[BW-1:0] = 16'h00AA; os_in_valid = 8'h01;
    repeat (5) tick();
    os_in_valid = '0; tick();
    n_vec++; if (o_empty !== 1'b0 || o_valid !== 1'b0) begin n_err++; $display("FAIL held_level status: got empty=%b valid=%b want 0 0", o_empty, o_valid); end
    pulse(8'hFE, rand_row());
    n_vec++; if (o_data[BW-1:0] !== 16'h00AA || o_valid !== m_valid()) begin n_err++; $display("FAIL held_level col0: got %h valid=%b want 00aa valid=1", o_data[BW-1:0], o_valid); end
    rd = 1'b1; tick(); rd = 1'b0;
    n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL held_level one_entry: got empty=%b want 1", o_empty); end
  endtask

  task automatic test_skew();
    logic [NC*BW-1:0] r;
    do_reset();
    r = '0; r[3*BW +: BW] = 16'h0031; pulse(8'h08, r);
    r[3*BW +: BW] = 16'h0032; pulse(8'h08, r);
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL skew early_valid: got %b want 0", o_valid); end
    pulse(8'hF7, rand_row());
    n_vec++; if (o_data[3*BW +: BW] !== 16'h0031 || o_data !== m_data()) begin n_err++; $display("FAIL skew row0: got %h want %h", o_data, m_data()); end
    rd = 1'b1; tick(); rd = 1'b0;
    n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL skew after_pop valid: got %b want 0", o_valid); end
    pulse(8'hF7, rand_row());
    n_vec++; if (o_data[3*BW +: BW] !== 16'h0032 || o_data !== m_data()) begin n_err++; $display("FAIL skew row1: got %h want %h", o_data, m_data()); end
    rd = 1'b1; tick(); rd = 1'b0;
  endtask

  task automatic test_overflow_and_full_pushpop();
    logic [NC*BW-1:0] vals [17];
    logic [NC*BW-1:0] nv;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      vals[i] = rand_row();
      pulse(8'hFF, vals[i]);
    end
    n_vec++; if (o_full !== 1'b1) begin n_err++; $display("FAIL ovf o_full: got %b want 1", o_full); end
    n_vec++; if (o_ovf !== 8'hFF) begin n_err++; $display("FAIL ovf o_ovf: got %h want ff", o_ovf); end
`ifdef OS_COLLECT_OVF_CNT_EN
    n_vec++; if (ovf_cnt !== 8'd8) begin n_err++; $display("FAIL ovf ovf_cnt: got %0d want 8", ovf_cnt); end
`endif
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (o_data !== vals[i] || o_valid !== 1'b1) begin n_err++; $display("FAIL ovf row%0d: got %h want %h", i, o_data, vals[i]); end
      rd = 1'b1; tick(); rd = 1'b0;
    end
    n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL ovf 17th_absent: got empty=%b want 1", o_empty); end
    for (int i = 0; i < 16; i++) begin
      vals[i] = rand_row();
      pulse(8'hFF, vals[i]);
    end
    nv = rand_row();
    os_in = nv; os_in_valid = 8'hFF; rd = 1'b1;
    tick();
    rd = 1'b0; os_in_valid = '0;
    tick();
    n_vec++; if (o_full !== 1'b1 || o_full !== m_full()) begin n_err++; $display("FAIL pushpop o_full: got %b want 1", o_full); end
    n_vec++; if (o_ovf !== 8'hFF) begin n_err++; $display("FAIL pushpop o_ovf: got %h want ff", o_ovf); end
`ifdef OS_COLLECT_OVF_CNT_EN
    n_vec++; if (ovf_cnt !== 8'd8) begin n_err++; $display("FAIL pushpop ovf_cnt: got %0d want 8", ovf_cnt); end
`endif
    for (int i = 1; i < 16; i++) begin
      n_vec++; if (o_data !== vals[i]) begin n_err++; $display("FAIL pushpop row%0d: got %h want %h", i, o_data, vals[i]); end
      rd = 1'b1; tick(); rd = 1'b0;
    end
    n_vec++; if (o_data !== nv || o_valid !== 1'b1) begin n_err++; $display("FAIL pushpop last_row: got %h want %h", o_data, nv); end
    rd = 1'b1; tick(); rd = 1'b0;
    n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL pushpop drained: got empty=%b want 1", o_empty); end
  endtask

  task automatic test_reset_mid();
    logic [NC*BW-1:0] v;
    do_reset();
    for (int i = 0; i < 5; i++) pulse(8'hFF, rand_row());
    n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL reset_mid pre valid: got %b want 1", o_valid); end
    v = rand_row();
    os_in = v; os_in_valid = 8'hFF; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (o_empty !== 1'b1 || o_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid cleared: got empty=%b valid=%b want 1 0", o_empty, o_valid); end
    tick();
    n_vec++; if (o_valid !== 1'b1 || o_data !== v) begin n_err++; $display("FAIL reset_mid recapture: got valid=%b data=%h want 1 %h", o_valid, o_data, v); end
    repeat (3) tick();
    rd = 1'b1; tick(); rd = 1'b0;
    n_vec++; if (o_empty !== 1'b1) begin n_err++; $display("FAIL reset_mid single: got empty=%b want 1", o_empty); end
    os_in_valid = '0; tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      os_in       = rand_row();
      os_in_valid = 8'($urandom);
      rd          = ($urandom_range(0, 3) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      tick();
      n_vec++; if (o_valid !== m_valid() || o_empty !== m_empty() || o_full !== m_full()) begin
        n_err++; $display("FAIL random status @%0d: got v/e/f=%b%b%b want %b%b%b", i, o_valid, o_empty, o_full, m_valid(), m_empty(), m_full());
      end
      n_vec++; if (o_ovf !== m_ovf) begin n_err++; $display("FAIL random o_ovf @%0d: got %h want %h", i, o_ovf, m_ovf); end
      if (m_valid()) begin
        n_vec++; if (o_data !== m_data()) begin n_err++; $display("FAIL random o_data @%0d: got %h want %h", i, o_data, m_data()); end
      end
`ifdef OS_COLLECT_OVF_CNT_EN
      n_vec++; if (ovf_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL random ovf_cnt @%0d: got %0d want %0d", i, ovf_cnt, m_cnt); end
`endif
    end
    reset = 1'b0; rd = 1'b0; os_in_valid = '0;
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; os_in = '0; os_in_valid = '0;
    m_prev = '0; m_ovf = '0; m_cnt = 0;
    test_reset();
    test_single_row();
    test_held_level();
    test_skew();
    test_overflow_and_full_pushpop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
